intm_rs: RTL and testbench
==========================

// Module: intm_rs
// PURPOSE
//  Reservation station for integer multiply/divide uops, between rename/dispatch and fu_mul/fu_div.
//  Holds up to DEPTH uops and snoops CDB broadcasts to capture source operands.
//  Issues one operand-ready uop per cycle to the downstream FU over a valid/ready handshake.
// PARAMETERS
//  DEPTH      4   number of RS entries (power of 2, >=2)
//  NUM_CDB    2   number of CDB snoop ports
//  ROB_IDX_W  5   ROB index width
//  PRF_IDX_W  6   physical register index width
//  OPC_W      3   fu_opcode width (MD_MUL..MD_REMU encodings)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous reset, active-high
//  flush        in   1                  pipeline flush (mispredict/exception)
//  dis_valid    in   1                  dispatch uop valid
//  dis_ready    out  1                  RS can accept a uop
//  dis_opcode   in   OPC_W              fu_opcode
//  dis_rob_id   in   ROB_IDX_W          ROB id
//  dis_rd_arch  in   5                  dest arch reg
//  dis_rd_phy   in   PRF_IDX_W          dest phys reg
//  dis_rsN_phy  in   PRF_IDX_W          source N phys tag (N=1,2)
//  dis_rsN_rdy  in   1                  source N value valid at dispatch
//  dis_rsN_val  in   32                 source N value (meaningful if rdy)
//  cdb_valid    in   NUM_CDB            CDB broadcast valid per port
//  cdb_rd_phy   in   NUM_CDB x PRF_IDX_W broadcast tag
//  cdb_rd_value in   NUM_CDB x 32       broadcast value
//  iss_valid    out  1                  uop ready to issue
//  iss_ready    in   1                  FU accepts (fu prv_ready)
//  iss_opcode / iss_rob_id / iss_rd_arch / iss_rd_phy / iss_rs1_value / iss_rs2_value  out  widths as dispatch
//  rs_count     out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
//  Reset/flush: all entry valid bits 0 next cycle; dis_ready=1, iss_valid=0, rs_count=0 after reset.
//  Entry: valid, opcode, rob_id, rd_arch, rd_phy, {rdy,phy,val} per source.
//  Dispatch: dis_ready = (rs_count < DEPTH), from registered state only; an entry freed by issue
//   this cycle is not reusable until next cycle. Accept on dis_valid&&dis_ready&&!flush into
//   lowest-index free entry.
//  Wakeup: each cycle, any valid entry source with rdy=0 and cdb_valid[k] && cdb_rd_phy[k]==phy
//   captures cdb_rd_value[k], rdy<=1. Tag 0 never matches (p0 is always dispatched ready, value 0).
//  Dispatch bypass: source dispatched rdy=0 whose tag matches a same-cycle CDB broadcast is
//   written with rdy=1 and the CDB value.
//  Multiple CDB ports matching one tag: lowest port index wins (values identical by construction).
//  Select: entry is issuable if valid && rs1.rdy && rs2.rdy (registered state; no same-cycle
//   wakeup-to-issue). Fixed priority: lowest index. iss_* combinational from selected entry.
//  iss_valid = any issuable && !flush. Entry freed on iss_valid && iss_ready; data held stable
//   while iss_valid && !iss_ready unless a higher-priority entry becomes issuable (allowed: FU
//   samples only on handshake).
//  rs_count next = rs_count + accept - issue; simultaneous accept+issue leaves count unchanged.
//  flush has priority over dispatch, wakeup and issue in the same cycle.
// CONFIGURATION
//  INTM_RS_AGE_SELECT_EN defined: select oldest issuable entry via DEPTHxDEPTH age matrix
//   (row set on dispatch, column cleared on free); older uop issues first regardless of index.
//  Not defined: fixed lowest-index priority as above; no age matrix is instantiated.
// TESTING
//  Reset, dispatch 4 ready uops (MD_MUL 3*5 etc.), iss_ready=1 -> 4 issues in consecutive cycles, rs_count 4->0.
//  Fill DEPTH=4 -> dis_ready=0; issue one -> dis_ready=1 only the following cycle.
//  Dispatch rs1 tag p9 not ready; CDB p9=0x1234 two cycles later -> iss_valid next cycle, iss_rs1_value=0x1234.
//  Dispatch with rs2 tag p7 while CDB broadcasts p7=0xBEEF same cycle -> entry issuable next cycle with 0xBEEF.
//  Hold iss_ready=0 for 5 cycles with 1 issuable entry -> iss_* stable, count unchanged; then flush -> iss_valid=0, rs_count=0.
//  AGE_SELECT_EN: dispatch A into entry 2 after freeing, then B into 0; both ready -> A issues before B.

Source files
------------

// File: rtl/intm_rs.sv
// ============================================================================
//  Module      : intm_rs
//  Description : Integer multiply/divide reservation station with CDB snoop,
//                dispatch bypass and one-per-cycle valid/ready issue.
//                Optional oldest-first select under INTM_RS_AGE_SELECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intm_rs #(
    parameter int DEPTH     = 4,
    parameter int NUM_CDB   = 2,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6,
    parameter int OPC_W     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               dis_valid,
    output logic                               dis_ready,
    input  logic [OPC_W-1:0]                   dis_opcode,
    input  logic [ROB_IDX_W-1:0]               dis_rob_id,
    input  logic [4:0]                         dis_rd_arch,
    input  logic [PRF_IDX_W-1:0]               dis_rd_phy,
    input  logic [PRF_IDX_W-1:0]               dis_rs1_phy,
    input  logic                               dis_rs1_rdy,
    input  logic [31:0]                        dis_rs1_val,
    input  logic [PRF_IDX_W-1:0]               dis_rs2_phy,
    input  logic                               dis_rs2_rdy,
    input  logic [31:0]                        dis_rs2_val,
    input  logic [NUM_CDB-1:0]                 cdb_valid,
    input  logic [NUM_CDB-1:0][PRF_IDX_W-1:0]  cdb_rd_phy,
    input  logic [NUM_CDB-1:0][31:0]           cdb_rd_value,
    output logic                               iss_valid,
    input  logic                               iss_ready,
    output logic [OPC_W-1:0]                   iss_opcode,
    output logic [ROB_IDX_W-1:0]               iss_rob_id,
    output logic [4:0]                         iss_rd_arch,
    output logic [PRF_IDX_W-1:0]               iss_rd_phy,
    output logic [31:0]                        iss_rs1_value,
    output logic [31:0]                        iss_rs2_value,
    output logic [$clog2(DEPTH):0]             rs_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]     ent_valid;
    logic [DEPTH-1:0]     s1_rdy;
    logic [DEPTH-1:0]     s2_rdy;
    logic [OPC_W-1:0]     ent_opc   [DEPTH];
    logic [ROB_IDX_W-1:0] ent_rob   [DEPTH];
    logic [4:0]           ent_arch  [DEPTH];
    logic [PRF_IDX_W-1:0] ent_rdphy [DEPTH];
    logic [PRF_IDX_W-1:0] s1_phy    [DEPTH];
    logic [PRF_IDX_W-1:0] s2_phy    [DEPTH];
    logic [31:0]          s1_val    [DEPTH];
    logic [31:0]          s2_val    [DEPTH];
    logic [CNT_W-1:0]     count;

    logic [DEPTH-1:0]     issuable;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     free_idx;
    logic                 accept;
    logic                 fire;

    // Physical register 0 is hardwired ready, so its tag is never snooped.
    function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0] tag);
        cdb_hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && (cdb_rd_phy[k] == tag) && (tag != '0)) begin
                cdb_hit = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] cdb_value(input logic [PRF_IDX_W-1:0] tag);
        cdb_value = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rd_phy[k] == tag)) begin
                cdb_value = cdb_rd_value[k];
            end
        end
    endfunction

    assign issuable  = ent_valid & s1_rdy & s2_rdy;
    assign dis_ready = (count < CNT_W'(DEPTH));
    assign accept    = dis_valid && dis_ready && !flush;
    assign iss_valid = (|issuable) && !flush;
    assign fire      = iss_valid && iss_ready;
    assign rs_count  = count;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef INTM_RS_AGE_SELECT_EN
    // age[i][j] set means entry j was already waiting when entry i arrived.
    logic [DEPTH-1:0] age [DEPTH];
    logic             found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && issuable[i] && ((age[i] & issuable) == '0)) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (accept && (free_idx == IDX_W'(i))) begin
                        age[i][j] <= ent_valid[j] && !(fire && (sel == IDX_W'(j)));
                    end else if (fire && (sel == IDX_W'(j))) begin
                        age[i][j] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                sel = IDX_W'(i);
            end
        end
    end
`endif

    assign iss_opcode    = ent_opc[sel];
    assign iss_rob_id    = ent_rob[sel];
    assign iss_rd_arch   = ent_arch[sel];
    assign iss_rd_phy    = ent_rdphy[sel];
    assign iss_rs1_value = s1_val[sel];
    assign iss_rs2_value = s2_val[sel];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid <= '0;
            count     <= '0;
        end else begin
            count <= count + CNT_W'(accept) - CNT_W'(fire);
            for (int i = 0; i < DEPTH; i++) begin
                if (fire && (sel == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b0;
                end else if (ent_valid[i]) begin
                    if (!s1_rdy[i] && cdb_hit(s1_phy[i])) begin
                        s1_rdy[i] <= 1'b1;
                        s1_val[i] <= cdb_value(s1_phy[i]);
                    end
                    if (!s2_rdy[i] && cdb_hit(s2_phy[i])) begin
                        s2_rdy[i] <= 1'b1;
                        s2_val[i] <= cdb_value(s2_phy[i]);
                    end
                end
                // The freed slot is never free_idx, so this cannot collide with the clear above.
                if (accept && (free_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b1;
                    ent_opc[i]   <= dis_opcode;
                    ent_rob[i]   <= dis_rob_id;
                    ent_arch[i]  <= dis_rd_arch;
                    ent_rdphy[i] <= dis_rd_phy;
                    s1_phy[i]    <= dis_rs1_phy;
                    s2_phy[i]    <= dis_rs2_phy;
                    if (!dis_rs1_rdy && cdb_hit(dis_rs1_phy)) begin
                        s1_rdy[i] <= 1'b1;
                        s1_val[i] <= cdb_value(dis_rs1_phy);
                    end else begin
                        s1_rdy[i] <= dis_rs1_rdy;
                        s1_val[i] <= dis_rs1_val;
                    end
                    if (!dis_rs2_rdy && cdb_hit(dis_rs2_phy)) begin
                        s2_rdy[i] <= 1'b1;
                        s2_val[i] <= cdb_value(dis_rs2_phy);
                    end else begin
                        s2_rdy[i] <= dis_rs2_rdy;
                        s2_val[i] <= dis_rs2_val;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_intm_rs.sv
// ============================================================================
//  Module      : tb_intm_rs
//  Description : Directed and randomized self-checking bench for intm_rs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intm_rs;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             dis_valid;
    logic             dis_ready;
    logic [2:0]       dis_opcode;
    logic [4:0]       dis_rob_id;
    logic [4:0]       dis_rd_arch;
    logic [5:0]       dis_rd_phy;
    logic [5:0]       dis_rs1_phy;
    logic             dis_rs1_rdy;
    logic [31:0]      dis_rs1_val;
    logic [5:0]       dis_rs2_phy;
    logic             dis_rs2_rdy;
    logic [31:0]      dis_rs2_val;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_rd_phy;
    logic [1:0][31:0] cdb_rd_value;
    logic             iss_valid;
    logic             iss_ready;
    logic [2:0]       iss_opcode;
    logic [4:0]       iss_rob_id;
    logic [4:0]       iss_rd_arch;
    logic [5:0]       iss_rd_phy;
    logic [31:0]      iss_rs1_value;
    logic [31:0]      iss_rs2_value;
    logic [2:0]       rs_count;

    int tests_run;
    int tests_failed;

    intm_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_opcode(dis_opcode),
        .dis_rob_id(dis_rob_id), .dis_rd_arch(dis_rd_arch), .dis_rd_phy(dis_rd_phy),
        .dis_rs1_phy(dis_rs1_phy), .dis_rs1_rdy(dis_rs1_rdy), .dis_rs1_val(dis_rs1_val),
        .dis_rs2_phy(dis_rs2_phy), .dis_rs2_rdy(dis_rs2_rdy), .dis_rs2_val(dis_rs2_val),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
        .iss_rob_id(iss_rob_id), .iss_rd_arch(iss_rd_arch), .iss_rd_phy(iss_rd_phy),
        .iss_rs1_value(iss_rs1_value), .iss_rs2_value(iss_rs2_value), .rs_count(rs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush = 0; dis_valid = 0; dis_opcode = 0; dis_rob_id = 0; dis_rd_arch = 0;
        dis_rd_phy = 0; dis_rs1_phy = 0; dis_rs1_rdy = 0; dis_rs1_val = 0;
        dis_rs2_phy = 0; dis_rs2_rdy = 0; dis_rs2_val = 0;
        cdb_valid = 0; cdb_rd_phy = '0; cdb_rd_value = '0; iss_ready = 0;
    endtask

    task automatic put(input logic [4:0] rob, input logic [5:0] p1, input logic r1,
                       input logic [31:0] v1, input logic [5:0] p2, input logic r2,
                       input logic [31:0] v2);
        dis_valid = 1; dis_opcode = rob[2:0]; dis_rob_id = rob; dis_rd_arch = rob + 5'd1;
        dis_rd_phy = {1'b1, rob}; dis_rs1_phy = p1; dis_rs1_rdy = r1; dis_rs1_val = v1;
        dis_rs2_phy = p2; dis_rs2_rdy = r2; dis_rs2_val = v2;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1;
        tick();
        tick();
        tests_run++;
        if ({dis_ready, iss_valid, rs_count} !== {1'b1, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset: ready/valid/count got %b %b %0d want 1 0 0",
                     dis_ready, iss_valid, rs_count);
        end
        rst = 0;
    endtask

    task automatic test_issue_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(5'(i), 6'd0, 1'b1, 32'(3 + i), 6'd0, 1'b1, 32'd5);
            tick();
        end
        clear_in();
        tests_run++;
        if (rs_count !== 3'd4 || dis_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill: count=%0d ready=%b want 4 0", rs_count, dis_ready);
        end
        iss_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (iss_valid !== 1'b1 || iss_rob_id !== 5'(i) || iss_rs1_value !== 32'(3 + i) ||
                iss_rs2_value !== 32'd5 || rs_count !== 3'(4 - i)) begin
                tests_failed++;
                $display("FAIL stream[%0d]: v=%b rob=%0d a=%0d b=%0d cnt=%0d want 1 %0d %0d 5 %0d",
                         i, iss_valid, iss_rob_id, iss_rs1_value, iss_rs2_value, rs_count,
                         i, 3 + i, 4 - i);
            end
            tick();
        end
        tests_run++;
        if (rs_count !== 3'd0 || iss_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: count=%0d valid=%b want 0 0", rs_count, iss_valid);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(5'(8 + i), 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd7);
            tick();
        end
        // Issue one while a dispatch is offered: the freed slot must not be reused yet.
        put(5'd20, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        iss_ready = 1;
        #1;
        tests_run++;
        if (dis_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_same_cycle: dis_ready=%b want 0", dis_ready);
        end
        tick();
        clear_in();
        tests_run++;
        if (dis_ready !== 1'b1 || rs_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL full_next_cycle: ready=%b count=%0d want 1 3", dis_ready, rs_count);
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        put(5'd1, 6'd9, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        tick();
        clear_in();
        tick();
        cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd9; cdb_rd_value[0] = 32'h1234;
        #1;
        tests_run++;
        if (iss_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wake_same_cycle: iss_valid=%b want 0", iss_valid);
        end
        tick();
        clear_in();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rs1_value !== 32'h1234) begin
            tests_failed++;
            $display("FAIL wakeup: valid=%b rs1=%h want 1 1234", iss_valid, iss_rs1_value);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        put(5'd2, 6'd0, 1'b1, 32'd4, 6'd7, 1'b0, 32'd0);
        cdb_valid = 2'b11;
        cdb_rd_phy[0] = 6'd3; cdb_rd_value[0] = 32'hDEAD;
        cdb_rd_phy[1] = 6'd7; cdb_rd_value[1] = 32'hBEEF;
        tick();
        clear_in();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rs2_value !== 32'hBEEF) begin
            tests_failed++;
            $display("FAIL bypass: valid=%b rs2=%h want 1 beef", iss_valid, iss_rs2_value);
        end
    endtask

    task automatic test_hold_flush();
        logic [82:0] held;
        do_reset();
        put(5'd13, 6'd0, 1'b1, 32'hA5, 6'd0, 1'b1, 32'h5A);
        tick();
        clear_in();
        held = {3'd5, 5'd13, 5'd14, 6'd45, 32'hA5, 32'h5A};
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (iss_valid !== 1'b1 || rs_count !== 3'd1 ||
                {iss_opcode, iss_rob_id, iss_rd_arch, iss_rd_phy, iss_rs1_value, iss_rs2_value} !== held) begin
                tests_failed++;
                $display("FAIL hold[%0d]: valid=%b count=%0d rob=%0d want 1 1 13", c,
                         iss_valid, rs_count, iss_rob_id);
            end
            tick();
        end
        flush = 1;
        iss_ready = 1;
        put(5'd3, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        #1;
        tests_run++;
        if (iss_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_valid: iss_valid=%b want 0", iss_valid);
        end
        tick();
        clear_in();
        tests_run++;
        if (rs_count !== 3'd0 || iss_valid !== 1'b0 || dis_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_state: count=%0d valid=%b ready=%b want 0 0 1",
                     rs_count, iss_valid, dis_ready);
        end
    endtask

`ifdef INTM_RS_AGE_SELECT_EN
    task automatic test_age();
        do_reset();
        put(5'd1, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0); tick();
        put(5'd2, 6'd21, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0); tick();
        put(5'd3, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);  tick();
        clear_in();
        iss_ready = 1;
        tick();
        iss_ready = 0;
        put(5'd10, 6'd22, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        tick();
        clear_in();
        cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd20; cdb_rd_value[0] = 32'd6;
        tick();
        clear_in();
        iss_ready = 1;
        tick();
        iss_ready = 0;
        put(5'd11, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2);
        cdb_valid = 2'b01; cdb_rd_phy[0] = 6'd22; cdb_rd_value[0] = 32'd9;
        tick();
        clear_in();
        iss_ready = 1;
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 5'd10) begin
            tests_failed++;
            $display("FAIL age_first: valid=%b rob=%0d want 1 10", iss_valid, iss_rob_id);
        end
        tick();
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 5'd11) begin
            tests_failed++;
            $display("FAIL age_second: valid=%b rob=%0d want 1 11", iss_valid, iss_rob_id);
        end
        clear_in();
    endtask
`endif

    // Behavioural model: slots filled lowest-free-first, selection by index or arrival order.
    function automatic bit cdb_find(input logic [5:0] tag, output logic [31:0] v);
        v = '0;
        if (tag == 6'd0) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_rd_phy[k] == tag) begin
                v = cdb_rd_value[k];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic test_random();
        bit          m_v [4];
        bit          m_r1 [4];
        bit          m_r2 [4];
        logic [5:0]  m_p1 [4];
        logic [5:0]  m_p2 [4];
        logic [31:0] m_v1 [4];
        logic [31:0] m_v2 [4];
        logic [82:0] m_pay [4];
        int          m_seq [4];
        int          m_cnt;
        int          seqctr;
        int          esel;
        int          slot;
        bit          fire;
        bit          acc;
        logic [31:0] wv;
        logic [82:0] got;
        do_reset();
        m_cnt = 0; seqctr = 0;
        for (int i = 0; i < 4; i++) m_v[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            clear_in();
            flush = ($urandom_range(0, 39) == 0);
            iss_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 6) begin
                put(5'($urandom), 6'($urandom_range(1, 12)), 1'($urandom), $urandom,
                    6'($urandom_range(1, 12)), 1'($urandom), $urandom);
                dis_opcode = 3'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    dis_rs2_phy = 6'd0; dis_rs2_rdy = 1'b1; dis_rs2_val = 32'd0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                cdb_valid[k] = ($urandom_range(0, 9) < 4);
                cdb_rd_phy[k] = 6'($urandom_range(1, 12));
                cdb_rd_value[k] = $urandom;
            end
            #1;
            esel = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef INTM_RS_AGE_SELECT_EN
                    if (esel < 0 || m_seq[i] < m_seq[esel]) esel = i;
`else
                    if (esel < 0) esel = i;
`endif
                end
            end
            tests_run++;
            if (iss_valid !== (esel >= 0 && !flush) || dis_ready !== (m_cnt < 4) ||
                rs_count !== 3'(m_cnt)) begin
                tests_failed++;
                $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b cnt=%0d want %b %b %0d", cyc,
                         iss_valid, dis_ready, rs_count, (esel >= 0 && !flush), (m_cnt < 4), m_cnt);
            end
            if (esel >= 0 && !flush) begin
                got = {iss_opcode, iss_rob_id, iss_rd_arch, iss_rd_phy, iss_rs1_value, iss_rs2_value};
                tests_run++;
                if (got !== {m_pay[esel][82:64], m_v1[esel], m_v2[esel]}) begin
                    tests_failed++;
                    $display("FAIL rand_payload[%0d]: got %h want %h", cyc, got,
                             {m_pay[esel][82:64], m_v1[esel], m_v2[esel]});
                end
            end
            if (flush) begin
                for (int i = 0; i < 4; i++) m_v[i] = 0;
                m_cnt = 0;
            end else begin
                fire = (esel >= 0) && iss_ready;
                acc = dis_valid && (m_cnt < 4);
                slot = -1;
                for (int i = 0; i < 4; i++) if (!m_v[i] && slot < 0) slot = i;
                for (int i = 0; i < 4; i++) begin
                    if (m_v[i]) begin
                        if (!m_r1[i] && cdb_find(m_p1[i], wv)) begin m_r1[i] = 1; m_v1[i] = wv; end
                        if (!m_r2[i] && cdb_find(m_p2[i], wv)) begin m_r2[i] = 1; m_v2[i] = wv; end
                    end
                end
                if (fire) m_v[esel] = 0;
                if (acc) begin
                    m_v[slot] = 1;
                    m_pay[slot] = {dis_opcode, dis_rob_id, dis_rd_arch, dis_rd_phy, 64'd0};
                    m_p1[slot] = dis_rs1_phy; m_r1[slot] = dis_rs1_rdy; m_v1[slot] = dis_rs1_val;
                    m_p2[slot] = dis_rs2_phy; m_r2[slot] = dis_rs2_rdy; m_v2[slot] = dis_rs2_val;
                    if (!dis_rs1_rdy && cdb_find(dis_rs1_phy, wv)) begin m_r1[slot] = 1; m_v1[slot] = wv; end
                    if (!dis_rs2_rdy && cdb_find(dis_rs2_phy, wv)) begin m_r2[slot] = 1; m_v2[slot] = wv; end
                    m_seq[slot] = seqctr;
                    seqctr++;
                end
                m_cnt = m_cnt + int'(acc) - int'(fire);
            end
            tick();
        end
        clear_in();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1;
        clear_in();
        test_reset();
        test_issue_stream();
        test_full();
        test_wakeup();
        test_bypass();
        test_hold_flush();
`ifdef INTM_RS_AGE_SELECT_EN
        test_age();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
